// File: rtl/factor_search_ctrl.sv
// factor_search_ctrl: walks ordered factor pairs through an external checker,
// stops on the first accepted pair or when the space is exhausted or pruned, and flags checker disagreement.
module factor_search_ctrl #(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [2*W-1:0] target_i,
  output logic [W-1:0]   cand1_o,
  output logic [W-1:0]   cand2_o,
  input  logic           chk_ok_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           found_o,
  output logic [W-1:0]   fac1_o,
  output logic [W-1:0]   fac2_o,
  output logic [CW-1:0]  n_eval_o,
  output logic           chk_err_o
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam logic [W-1:0] MAXC = '1;
  localparam logic [W-1:0] TWO  = W'(2);
  state_t         state_q;
  logic [2*W-1:0] tgt_q;
  logic [W-1:0]   cand1_q, cand2_q, fac1_q, fac2_q;
  logic [CW-1:0]  n_eval_q;
  logic           busy_q, done_q, found_q, chk_err_q;
  logic [2*W-1:0] prod;
  logic           ref_ok, over, adv, stop;
  // The product of two W-bit candidates always fits in 2W bits.
  assign prod   = (2*W)'(cand1_q) * (2*W)'(cand2_q);
  assign ref_ok = prod == tgt_q;
  assign over   = prod > tgt_q;
  assign adv    = over || cand2_q == MAXC;
  assign stop   = (over && cand2_q == cand1_q) || (adv && cand1_q == MAXC);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tgt_q     <= '0;
      cand1_q   <= '0;
      cand2_q   <= '0;
      fac1_q    <= '0;
      fac2_q    <= '0;
      n_eval_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      found_q   <= 1'b0;
      chk_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        SCAN: begin
          n_eval_q <= n_eval_q + CW'(1);
          if (chk_ok_i != ref_ok) chk_err_q <= 1'b1;
          if (chk_ok_i) begin
            found_q <= 1'b1;
            fac1_q  <= cand1_q;
            fac2_q  <= cand2_q;
          end
          if (chk_ok_i || stop) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (adv) begin
            cand1_q <= cand1_q + W'(1);
            cand2_q <= cand1_q + W'(1);
          end else begin
            cand2_q <= cand2_q + W'(1);
          end
        end
        default: begin
          if (start_i) begin
            state_q   <= SCAN;
            tgt_q     <= target_i;
            cand1_q   <= TWO;
            cand2_q   <= TWO;
            fac1_q    <= '0;
            fac2_q    <= '0;
            n_eval_q  <= '0;
            found_q   <= 1'b0;
            chk_err_q <= 1'b0;
            busy_q    <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end
  assign cand1_o   = cand1_q;
  assign cand2_o   = cand2_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign found_o   = found_q;
  assign fac1_o    = fac1_q;
  assign fac2_o    = fac2_q;
  assign n_eval_o  = n_eval_q;
  assign chk_err_o = chk_err_q;
endmodule

// File: tb/tb_factor_search_ctrl.sv
// tb_factor_search_ctrl: drives factor_search_ctrl with a behavioural checker (optionally faulty at one pair)
// and compares results against a loop-based search model.
module tb_factor_search_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic [7:0] target_i = '0;
  logic [3:0] cand1_o, cand2_o, fac1_o, fac2_o;
  logic       chk_ok_i, busy_o, done_o, found_o, chk_err_o;
  logic [7:0] n_eval_o;
  logic [7:0] tb_tgt = '0;
  logic       fault_en = 1'b0;
  logic [3:0] fa = '0, fb = '0;
  logic [7:0] tb_p;
  int         n_cmp = 0, n_bad = 0;

  factor_search_ctrl #(.W(4), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .target_i(target_i),
    .cand1_o(cand1_o), .cand2_o(cand2_o), .chk_ok_i(chk_ok_i),
    .busy_o(busy_o), .done_o(done_o), .found_o(found_o),
    .fac1_o(fac1_o), .fac2_o(fac2_o), .n_eval_o(n_eval_o), .chk_err_o(chk_err_o)
  );

  always #5 clk = ~clk;

  // Checker stand-in: correct product compare, plus an optional false accept at (fa,fb).
  assign tb_p     = cand1_o * cand2_o;
  assign chk_ok_i = (tb_p == tb_tgt) || (fault_en && cand1_o == fa && cand2_o == fb);

  // Reference: enumerate pairs a<=b in order, stop on accept, prune when a square overshoots.
  task automatic model(input logic [7:0] t, input bit fe, input logic [3:0] a0, input logic [3:0] b0,
                       output bit mf, output logic [3:0] mf1, output logic [3:0] mf2,
                       output int mn, output bit merr);
    bit stop = 0;
    mf = 0; mf1 = 0; mf2 = 0; mn = 0; merr = 0;
    for (int a = 2; a < 16 && !stop; a++) begin
      for (int b = a; b < 16 && !stop; b++) begin
        int  p;
        bit  ok;
        p  = a * b;
        ok = (p == int'(t)) || (fe && a == int'(a0) && b == int'(b0));
        mn++;
        if (ok != (p == int'(t))) merr = 1;
        if (ok) begin
          mf = 1; mf1 = 4'(a); mf2 = 4'(b); stop = 1;
        end else if (p > int'(t)) begin
          if (a == b) stop = 1;
          break;
        end
      end
    end
  endtask

  task automatic launch(input logic [7:0] t);
    target_i = t;
    tb_tgt   = t;
    start_i  = 1'b1;
    @(posedge clk); #1;
    start_i  = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done_o !== 1'b1 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({cand1_o, cand2_o, busy_o, done_o, found_o, fac1_o, fac2_o, n_eval_o, chk_err_o} !== '0) begin
      n_bad++;
      $display("FAIL reset outputs got c=(%0d,%0d) busy=%b done=%b found=%b fac=(%0d,%0d) n=%0d err=%b want all 0",
               cand1_o, cand2_o, busy_o, done_o, found_o, fac1_o, fac2_o, n_eval_o, chk_err_o);
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_hold got busy=%b done=%b want 0 0", busy_o, done_o);
    end
  endtask

  task automatic test_search(input logic [7:0] t, input bit fe, input logic [3:0] a0, input logic [3:0] b0);
    bit mf, merr;
    logic [3:0] mf1, mf2;
    int mn, cyc;
    fault_en = fe; fa = a0; fb = b0;
    model(t, fe, a0, b0, mf, mf1, mf2, mn, merr);
    launch(t);
    n_cmp++;
    if (busy_o !== 1'b1 || cand1_o !== 4'd2 || cand2_o !== 4'd2 || n_eval_o !== 8'd0) begin
      n_bad++;
      $display("FAIL t=%0d scan_entry got busy=%b c=(%0d,%0d) n=%0d want 1 (2,2) 0", t, busy_o, cand1_o, cand2_o, n_eval_o);
    end
    wait_done(cyc);
    n_cmp++;
    if (cyc != mn) begin
      n_bad++;
      $display("FAIL t=%0d latency got %0d want %0d", t, cyc, mn);
    end
    n_cmp++;
    if (found_o !== mf || fac1_o !== mf1 || fac2_o !== mf2) begin
      n_bad++;
      $display("FAIL t=%0d result got found=%b fac=(%0d,%0d) want found=%b fac=(%0d,%0d)", t, found_o, fac1_o, fac2_o, mf, mf1, mf2);
    end
    n_cmp++;
    if (n_eval_o !== 8'(mn)) begin
      n_bad++;
      $display("FAIL t=%0d n_eval got %0d want %0d", t, n_eval_o, mn);
    end
    n_cmp++;
    if (chk_err_o !== merr || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL t=%0d err_busy got err=%b busy=%b want err=%b busy=0", t, chk_err_o, busy_o, merr);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || found_o !== mf || fac1_o !== mf1 || n_eval_o !== 8'(mn)) begin
      n_bad++;
      $display("FAIL t=%0d after_done got done=%b busy=%b found=%b fac1=%0d n=%0d want 0 0 %b %0d %0d",
               t, done_o, busy_o, found_o, fac1_o, n_eval_o, mf, mf1, mn);
    end
    fault_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc;
    fault_en = 1'b0;
    launch(8'd0);
    wait_done(cyc);
    n_cmp++;
    if (cyc != 1 || found_o !== 1'b0 || n_eval_o !== 8'd1) begin
      n_bad++;
      $display("FAIL b2b_t0 got cyc=%0d found=%b n=%0d want 1 0 1", cyc, found_o, n_eval_o);
    end
    launch(8'd225);
    n_cmp++;
    if (done_o !== 1'b0 || busy_o !== 1'b1 || n_eval_o !== 8'd0) begin
      n_bad++;
      $display("FAIL b2b_restart got done=%b busy=%b n=%0d want 0 1 0", done_o, busy_o, n_eval_o);
    end
    wait_done(cyc);
    n_cmp++;
    if (cyc != 105 || found_o !== 1'b1 || fac1_o !== 4'd15 || fac2_o !== 4'd15 || n_eval_o !== 8'd105) begin
      n_bad++;
      $display("FAIL b2b_t225 got cyc=%0d found=%b fac=(%0d,%0d) n=%0d want 105 1 (15,15) 105",
               cyc, found_o, fac1_o, fac2_o, n_eval_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fault();
    int cyc;
    fault_en = 1'b1; fa = 4'd3; fb = 4'd4;
    launch(8'd255);
    wait_done(cyc);
    n_cmp++;
    if (found_o !== 1'b1 || fac1_o !== 4'd3 || fac2_o !== 4'd4 || chk_err_o !== 1'b1 || n_eval_o !== 8'd16) begin
      n_bad++;
      $display("FAIL fault_255 got found=%b fac=(%0d,%0d) err=%b n=%0d want 1 (3,4) 1 16",
               found_o, fac1_o, fac2_o, chk_err_o, n_eval_o);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (chk_err_o !== 1'b1) begin
      n_bad++;
      $display("FAIL fault_sticky got err=%b want 1", chk_err_o);
    end
    fault_en = 1'b0;
    launch(8'd15);
    n_cmp++;
    if (chk_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL fault_clear got err=%b want 0", chk_err_o);
    end
    wait_done(cyc);
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    int done_seen = 0;
    fault_en = 1'b0;
    launch(8'd143);
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cand1_o, cand2_o, busy_o, done_o, found_o, fac1_o, fac2_o, n_eval_o, chk_err_o} !== '0) begin
      n_bad++;
      $display("FAIL midreset_async got c=(%0d,%0d) busy=%b done=%b n=%0d want all 0", cand1_o, cand2_o, busy_o, done_o, n_eval_o);
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) done_seen++;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (done_o === 1'b1 || busy_o === 1'b1) done_seen++;
    end
    n_cmp++;
    if (done_seen != 0) begin
      n_bad++;
      $display("FAIL midreset_quiet got %0d done/busy cycles want 0", done_seen);
    end
    test_search(8'd143, 1'b0, 4'd0, 4'd0);
    n_cmp++;
    if (fac1_o !== 4'd11 || fac2_o !== 4'd13) begin
      n_bad++;
      $display("FAIL midreset_rerun got fac=(%0d,%0d) want (11,13)", fac1_o, fac2_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      logic [7:0] t;
      logic [3:0] a0, b0;
      bit fe;
      t  = 8'($urandom_range(0, 255));
      fe = ($urandom_range(0, 2) == 0);
      a0 = 4'($urandom_range(2, 15));
      b0 = 4'($urandom_range(int'(a0), 15));
      test_search(t, fe, a0, b0);
    end
  endtask

  initial begin
    test_reset();
    test_search(8'd15, 1'b0, 4'd0, 4'd0);
    test_search(8'd13, 1'b0, 4'd0, 4'd0);
    test_back_to_back();
    test_fault();
    test_search(8'd221, 1'b0, 4'd0, 4'd0);
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
